// File: rtl/uart_tune_ctrl.sv
// uart_tune_ctrl: byte-command controller for the NCO phase increment.
// Supports absolute load, saturating fine/coarse steps and serial readback.
module uart_tune_ctrl #(
  parameter int unsigned PHASE_W      = 64,
  parameter logic [63:0] INIT_INC     = 64'h0104376A9DD10437,
  parameter logic [63:0] STEP_FINE    = 64'h00007B5CA45266E2,
  parameter logic [63:0] STEP_COARSE  = 64'h00045641C6E59DF0,
  parameter int unsigned TIMEOUT_CLKS = 1360000
) (
  input  logic               osc_clk,
  input  logic               reset,
  input  logic               rx_dv,
  input  logic [7:0]         rx_byte,
  input  logic               tx_active,
  input  logic               tx_done,
  output logic               tx_dv,
  output logic [7:0]         tx_byte,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               inc_update,
  output logic               cmd_err,
  output logic               busy
);

  localparam int unsigned N_BYTES = PHASE_W / 8;
  localparam int unsigned CNT_W   = $clog2(N_BYTES + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned EXT_W   = PHASE_W + 1;
  localparam int unsigned SHR_W   = PHASE_W - 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_TX_REQ  = 3'd3;
  localparam logic [2:0] S_TX_WAIT = 3'd4;

  localparam logic [PHASE_W-1:0] INC_RST = INIT_INC[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] FINE    = STEP_FINE[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] COARSE  = STEP_COARSE[PHASE_W-1:0];
  localparam logic [PHASE_W-1:0] MAXI    = {1'b0, {(PHASE_W-1){1'b1}}};

  logic [2:0]         state, state_n;
  logic [PHASE_W-1:0] inc_n;
  logic [SHR_W-1:0]   rx_shift, rx_shift_n;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_n;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic [PHASE_W-1:0] tx_shift, tx_shift_n;
  logic [CNT_W-1:0]   tx_left, tx_left_n;
  logic               tx_dv_n;
  logic [7:0]         tx_byte_n;
  logic               cmd_err_n;

  // Step with one guard bit: borrow clamps to 0, anything past Nyquist clamps to MAXI.
  function automatic logic [PHASE_W-1:0] step_sat(input logic [PHASE_W-1:0] cur,
                                                  input logic [PHASE_W-1:0] step,
                                                  input logic               sub);
    logic [EXT_W-1:0] r;
    if (sub) r = {1'b0, cur} - {1'b0, step};
    else     r = {1'b0, cur} + {1'b0, step};
    if (sub && r[PHASE_W])      step_sat = '0;
    else if (r > {1'b0, MAXI})  step_sat = MAXI;
    else                        step_sat = r[PHASE_W-1:0];
  endfunction

  // Next-state and next-output decode.
  always_comb begin
    state_n    = state;
    inc_n      = phase_inc;
    rx_shift_n = rx_shift;
    byte_cnt_n = byte_cnt;
    to_cnt_n   = to_cnt;
    tx_shift_n = tx_shift;
    tx_left_n  = tx_left;
    tx_dv_n    = 1'b0;
    tx_byte_n  = tx_byte;
    cmd_err_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_dv) begin
          case (rx_byte)
            8'h46: begin
              rx_shift_n = '0;
              byte_cnt_n = '0;
              to_cnt_n   = '0;
              state_n    = S_LOAD;
            end
            8'h2B: begin inc_n = step_sat(phase_inc, FINE,   1'b0); state_n = S_ACK; end
            8'h2D: begin inc_n = step_sat(phase_inc, FINE,   1'b1); state_n = S_ACK; end
            8'h75: begin inc_n = step_sat(phase_inc, COARSE, 1'b0); state_n = S_ACK; end
            8'h64: begin inc_n = step_sat(phase_inc, COARSE, 1'b1); state_n = S_ACK; end
            8'h3F: begin
              tx_shift_n = phase_inc;
              tx_left_n  = CNT_W'(N_BYTES);
              state_n    = S_TX_REQ;
            end
            default: cmd_err_n = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (rx_dv) begin
          to_cnt_n   = '0;
          rx_shift_n = SHR_W'({rx_shift, rx_byte});
          if (byte_cnt == CNT_W'(N_BYTES - 1)) begin
            inc_n   = {rx_shift, rx_byte};
            state_n = S_ACK;
          end else begin
            byte_cnt_n = byte_cnt + 1'b1;
          end
        end else if (to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
          cmd_err_n = 1'b1;
          state_n   = S_IDLE;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      S_ACK: begin
        tx_shift_n = {8'h4B, {(PHASE_W-8){1'b0}}};
        tx_left_n  = CNT_W'(1);
        state_n    = S_TX_REQ;
      end
      S_TX_REQ: begin
        if (!tx_active) begin
          tx_dv_n    = 1'b1;
          tx_byte_n  = tx_shift[PHASE_W-1 -: 8];
          tx_shift_n = tx_shift << 8;
          tx_left_n  = tx_left - 1'b1;
          state_n    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (tx_done) state_n = (tx_left == '0) ? S_IDLE : S_TX_REQ;
      end
      default: state_n = S_IDLE;
    endcase

    // Bytes arriving while a response is pending are dropped and flagged.
    if (rx_dv && (state == S_ACK || state == S_TX_REQ || state == S_TX_WAIT))
      cmd_err_n = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase_inc  <= INC_RST;
      rx_shift   <= '0;
      byte_cnt   <= '0;
      to_cnt     <= '0;
      tx_shift   <= '0;
      tx_left    <= '0;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'h00;
      inc_update <= 1'b0;
      cmd_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      phase_inc  <= inc_n;
      rx_shift   <= rx_shift_n;
      byte_cnt   <= byte_cnt_n;
      to_cnt     <= to_cnt_n;
      tx_shift   <= tx_shift_n;
      tx_left    <= tx_left_n;
      tx_dv      <= tx_dv_n;
      tx_byte    <= tx_byte_n;
      inc_update <= (inc_n != phase_inc);
      cmd_err    <= cmd_err_n;
      busy       <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tune_ctrl.sv
// Bench for uart_tune_ctrl: word-level model plus stalling transmitter emulation.
module tb_uart_tune_ctrl;

  localparam int unsigned T_TO  = 400;
  localparam int unsigned STALL = 1000;
  localparam logic [63:0] INIT   = 64'h0104376A9DD10437;
  localparam logic [63:0] FINE   = 64'h00007B5CA45266E2;
  localparam logic [63:0] COARSE = 64'h00045641C6E59DF0;
  localparam logic [63:0] MAXI   = 64'h7FFFFFFFFFFFFFFF;

  logic        osc_clk = 1'b0;
  logic        reset, rx_dv, tx_active, tx_done;
  logic [7:0]  rx_byte;
  logic        tx_dv, inc_update, cmd_err, busy;
  logic [7:0]  tx_byte;
  logic [63:0] phase_inc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_inc, m_word;
  logic        exp_upd, exp_err;
  int          m_mode, m_nbytes, m_idle, m_pending;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          stall;
  logic        chk_en = 1'b0;
  int          err_seen = 0;
  int          upd_seen = 0;

  uart_tune_ctrl #(
    .PHASE_W(64), .INIT_INC(INIT), .STEP_FINE(FINE),
    .STEP_COARSE(COARSE), .TIMEOUT_CLKS(T_TO)
  ) dut (
    .osc_clk(osc_clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_active(tx_active), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .phase_inc(phase_inc), .inc_update(inc_update), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%h want 0x%h", name, got, want);
    end
  endtask

  // Saturating step computed with signed wide arithmetic.
  function automatic logic [63:0] m_step(input logic [63:0] cur, input logic [63:0] st, input bit sub);
    logic signed [66:0] v;
    v = sub ? ($signed({3'b000, cur}) - $signed({3'b000, st}))
            : ($signed({3'b000, cur}) + $signed({3'b000, st}));
    if (v < 0) return 64'd0;
    if (v > $signed({3'b000, MAXI})) return MAXI;
    return v[63:0];
  endfunction

  task automatic m_apply(input logic [63:0] v);
    exp_upd   = (v != exp_inc);
    exp_inc   = v;
    m_mode    = 2;
    m_pending = 1;
    exp_q.push_back(8'h4B);
  endtask

  task automatic m_cmd(input logic [7:0] b);
    case (b)
      8'h46: begin m_mode = 1; m_nbytes = 0; m_word = '0; m_idle = 0; end
      8'h2B: m_apply(m_step(exp_inc, FINE, 1'b0));
      8'h2D: m_apply(m_step(exp_inc, FINE, 1'b1));
      8'h75: m_apply(m_step(exp_inc, COARSE, 1'b0));
      8'h64: m_apply(m_step(exp_inc, COARSE, 1'b1));
      8'h3F: begin
        m_mode = 2;
        m_pending = 8;
        for (int i = 7; i >= 0; i--) exp_q.push_back(exp_inc[i*8 +: 8]);
      end
      default: exp_err = 1'b1;
    endcase
  endtask

  // One clock: model consumes the inputs sampled at this edge, then the transmitter reacts.
  task automatic tick();
    logic act_s;
    @(posedge osc_clk);
    #1;
    act_s   = tx_active;
    exp_upd = 1'b0;
    exp_err = 1'b0;
    if (reset) begin
      exp_inc   = INIT;
      m_mode    = 0;
      m_pending = 0;
    end else begin
      if (rx_dv) begin
        if (m_mode == 0) m_cmd(rx_byte);
        else if (m_mode == 1) begin
          m_word = {m_word[55:0], rx_byte};
          m_nbytes++;
          m_idle = 0;
          if (m_nbytes == 8) m_apply(m_word);
        end else exp_err = 1'b1;
      end else if (m_mode == 1) begin
        m_idle++;
        if (m_idle == int'(T_TO)) begin exp_err = 1'b1; m_mode = 0; end
      end
      if (tx_done && m_mode == 2) begin
        m_pending--;
        if (m_pending == 0) m_mode = 0;
      end
    end
    if (reset) begin
      tx_active = 1'b0; tx_done = 1'b0; stall = 0;
    end else begin
      tx_done = 1'b0;
      if (stall > 0) begin
        stall--;
        if (stall == 0) begin tx_active = 1'b0; tx_done = 1'b1; end
      end
      if (tx_dv === 1'b1) begin
        chk("tx_dv_while_active", 64'(act_s), 64'd0);
        got_q.push_back(tx_byte);
        tx_active = 1'b1;
        stall = STALL;
      end
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge osc_clk) begin
    if (chk_en) begin
      chk("phase_inc",  phase_inc,         exp_inc);
      chk("inc_update", 64'(inc_update),   64'(exp_upd));
      chk("cmd_err",    64'(cmd_err),      64'(exp_err));
      chk("busy",       64'(busy),         64'(m_mode != 0));
      err_seen += 32'(cmd_err);
      upd_seen += 32'(inc_update);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    tick();
    rx_dv   = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20000; i++) begin
      if (m_mode == 0) break;
      tick();
    end
    chk({name, "_idle_bound"}, 64'(m_mode), 64'd0);
  endtask

  task automatic chk_tx(input string name);
    chk({name, "_tx_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_tx_byte"}, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic load(input logic [63:0] v, input string name);
    send(8'h46);
    for (int i = 7; i >= 0; i--) send(v[i*8 +: 8]);
    wait_idle(name);
    chk_tx(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb_lit [8];
    int e0, u0;
    rb_lit = '{8'h01, 8'h04, 8'h37, 8'h6A, 8'h9D, 8'hD1, 8'h04, 8'h37};
    reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; tx_active = 1'b0; tx_done = 1'b0;
    stall = 0; exp_inc = INIT; exp_upd = 1'b0; exp_err = 1'b0;
    m_mode = 0; m_nbytes = 0; m_idle = 0; m_pending = 0; m_word = '0;

    repeat (3) tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    tick();
    chk("rst_phase_inc", phase_inc, 64'h0104376A9DD10437);
    chk("rst_tx_dv",     64'(tx_dv),      64'd0);
    chk("rst_tx_byte",   64'(tx_byte),    64'd0);
    chk("rst_inc_update",64'(inc_update), 64'd0);
    chk("rst_cmd_err",   64'(cmd_err),    64'd0);
    chk("rst_busy",      64'(busy),       64'd0);

    // Readback with a stray byte in the middle.
    send(8'h3F);
    repeat (2500) tick();
    e0 = err_seen;
    send(8'h78);
    chk("rb_stray_err", 64'(err_seen - e0), 64'd1);
    wait_idle("rb");
    chk("rb_lit_count", 64'(got_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("rb_lit_byte", 64'(got_q[i]), 64'(rb_lit[i]));
    chk_tx("rb");

    // Fine step up.
    u0 = upd_seen;
    send(8'h2B);
    chk("step_value", phase_inc, 64'h0104B2C742236B19);
    wait_idle("step");
    chk("step_upd_pulses", 64'(upd_seen - u0), 64'd1);
    chk("step_k_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) chk("step_k_byte", 64'(got_q[0]), 64'h4B);
    chk_tx("step");

    // Absolute load: value must not move until the last byte.
    send(8'h46);
    send(8'h01);
    for (int i = 0; i < 6; i++) send(8'hB1);
    chk("load_partial", phase_inc, 64'h0104B2C742236B19);
    send(8'hB1);
    chk("load_value", phase_inc, 64'h01B1B1B1B1B1B1B1);
    wait_idle("load");
    chk_tx("load");

    // Load timeout after three bytes.
    send(8'h46);
    send(8'h12); send(8'h34); send(8'h56);
    e0 = err_seen;
    repeat (T_TO + 20) tick();
    chk("to_err_pulses", 64'(err_seen - e0), 64'd1);
    chk("to_phase_inc", phase_inc, 64'h01B1B1B1B1B1B1B1);
    chk("to_busy", 64'(busy), 64'd0);
    chk_tx("to");

    // Saturation at both ends.
    load(64'h0000000000000001, "sat_lo_load");
    send(8'h64);
    chk("sat_lo_value", phase_inc, 64'd0);
    wait_idle("sat_lo");
    chk_tx("sat_lo");
    load(64'h7FFFFFFFFFFFFFF0, "sat_hi_load");
    send(8'h75);
    chk("sat_hi_value", phase_inc, 64'h7FFFFFFFFFFFFFFF);
    wait_idle("sat_hi");
    chk_tx("sat_hi");
    u0 = upd_seen;
    send(8'h75);
    chk("sat_rep_value", phase_inc, 64'h7FFFFFFFFFFFFFFF);
    wait_idle("sat_rep");
    chk("sat_rep_upd_pulses", 64'(upd_seen - u0), 64'd0);
    chk_tx("sat_rep");
    send(8'h2D);
    wait_idle("fine_dn");
    chk_tx("fine_dn");

    // Reset in the middle of a readback.
    send(8'h3F);
    repeat (1500) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_busy",  64'(busy),  64'd0);
    chk("mid_rst_tx_dv", 64'(tx_dv), 64'd0);
    chk("mid_rst_phase_inc", phase_inc, 64'h0104376A9DD10437);
    got_q.delete();
    exp_q.delete();
    repeat (3000) tick();
    chk("mid_rst_no_tx", 64'(got_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tune_ctrl.md
Name: uart_tune_ctrl

Overview:
- UART-driven tuning controller for the NCO phase increment.
- Sits between uart_rx/uart_tx and nco_sig in the receiver top level, all on osc_clk; its phase_inc output drives the NCO's phase_inc_carr input.
- Parses single-byte commands: absolute load, fine and coarse frequency steps, and readback.
- Replaces the fixed, hand-edited phase increment with a runtime-tunable register that has saturation, a load timeout and serial readback.

Parameters:
- PHASE_W, 64, phase increment width; multiple of 8, range 16..64.
- INIT_INC, 64'h104376A9DD10437, reset value of phase_inc (540 kHz at 136 MHz); truncated to PHASE_W LSBs.
- STEP_FINE, 64'h7B5CA45266E2, increment for the '+'/'-' commands (1 kHz).
- STEP_COARSE, 64'h45641C6E59DF0, increment for the 'u'/'d' commands (9 kHz).
- TIMEOUT_CLKS, 1360000, maximum idle gap between bytes of a load sequence (10 ms).

Ports:
- osc_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_dv  in  1  one-cycle strobe: rx_byte valid.
- rx_byte  in  8  received byte.
- tx_active  in  1  UART transmitter busy.
- tx_done  in  1  one-cycle strobe: transmitter finished a byte.
- tx_dv  out  1  one-cycle strobe: send tx_byte.
- tx_byte  out  8  byte to transmit.
- phase_inc  out  PHASE_W  current NCO phase increment.
- inc_update  out  1  one-cycle pulse whenever phase_inc changes value.
- cmd_err  out  1  one-cycle pulse on a protocol error.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock, osc_clk. Reset is synchronous and active-high.
- Reset values: phase_inc=INIT_INC; tx_dv=0; tx_byte=0; inc_update=0; cmd_err=0; busy=0; state=IDLE; byte and timeout counters=0.
- Reset asserted mid-load or mid-readback aborts immediately. A partial load never reaches phase_inc.
- N = PHASE_W/8 bytes.
- States: IDLE, LOAD, ACK, TX_REQ, TX_WAIT.
- IDLE, on rx_dv:
  - 0x46 'F': clear shift register and byte count -> LOAD.
  - 0x2B '+': add STEP_FINE.
  - 0x2D '-': subtract STEP_FINE.
  - 0x75 'u': add STEP_COARSE.
  - 0x64 'd': subtract STEP_COARSE.
  - 0x3F '?': latch phase_inc into the tx shift register -> TX_REQ (N bytes, MSB first).
  - Any other byte: pulse cmd_err, stay IDLE, no transmit.
- Step arithmetic:
  - Computed at PHASE_W+1 bits.
  - Result above MAXI = 2^(PHASE_W-1)-1 (Nyquist) clamps to MAXI.
  - Result below 0 clamps to 0.
  - Step commands update phase_inc on the cycle after rx_dv -> ACK.
- LOAD:
  - Each rx_dv shifts rx_byte in, MSB first.
  - After byte N: phase_inc takes the whole word atomically on the next cycle -> ACK.
  - A loaded value above MAXI is accepted unclamped; the load is raw.
  - Timeout counter clears on each byte. Reaching TIMEOUT_CLKS: pulse cmd_err, phase_inc unchanged -> IDLE.
- inc_update: pulses in the cycle phase_inc changes. No pulse if the new value equals the old value, including a saturated step.
- ACK: queues a single byte 0x4B 'K' -> TX_REQ.
- TX_REQ: wait until tx_active=0, then assert tx_dv for exactly one cycle with tx_byte valid -> TX_WAIT.
- TX_WAIT: on tx_done, either send the next byte (-> TX_REQ) or return to IDLE after the last byte. Readback sends no 'K'.
- rx_dv outside IDLE/LOAD (ACK, TX_REQ, TX_WAIT): byte dropped, cmd_err pulses.
- Latency:
  - '+' rx_dv at cycle t -> phase_inc valid at t+1.
  - First tx_dv no earlier than t+2, given tx_active=0.
- busy = (state != IDLE).

Test Plan:
- Reset release -> phase_inc=0x0104376A9DD10437, outputs 0, busy=0.
- Step: rx 0x2B -> phase_inc=0x0104376A9DD10437+0x7B5CA45266E2 at t+1; inc_update one pulse; tx 0x4B once.
- Load: rx 0x46, then 0x01,0xB1,0xB1,0xB1,0xB1,0xB1,0xB1,0xB1 (900 kHz) -> phase_inc=0x01B1B1B1B1B1B1B1 only after the 8th byte; then 'K'.
- Load timeout: 'F' + 3 bytes, then no input for 1360000 clocks -> cmd_err pulse, phase_inc unchanged, busy=0; no 'K'.
- Saturation: load 0x0000000000000001, then 'd' -> phase_inc=0. Load 0x7FFFFFFFFFFFFFF0, then 'u' -> 0x7FFFFFFFFFFFFFFF. A repeated 'u' gives no inc_update pulse.
- Readback with a stalling transmitter model (tx_active held 1000 clocks per byte) -> 8 tx_dv pulses, bytes 01,04,37,6A,9D,D1,04,37. An 'x' sent mid-readback -> cmd_err, sequence undisturbed. Reset mid-readback -> IDLE, tx_dv=0.
